dice_roller_mux: RTL and testbench

- Parametrised successor to the single-die 7-segment roller: rolls N_DICE independent dice of FACES sides each.
- Provides debounced active-low start/stop buttons, a staggered per-die spin rate and a decelerating stop phase.
- Outputs a registered result, the sum of all dice and a done pulse, and time-multiplexes all dice onto the 8-digit common-anode display.
- Sits between the board buttons/display and any downstream scoring logic.

---
 rtl/dice_pkg.sv | 47 ++++
 rtl/button_conditioner.sv | 56 +++++
 rtl/dice_roller_mux.sv | 180 ++++++++++++++++++
 tb/tb_dice_roller_mux.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// dice_pkg: shared definitions for the multi-die roller.
//   - FSM state encoding (IDLE / ROLL / SLOW)
//   - face / phase / display width constants
//   - seg7(): active-low 7-segment pattern for a face value {p,g,f,e,d,c,b,a}
//   - face_next(): wrap-around advance of a single die
//   - width_for(): counter width able to hold 0..max_value
package dice_pkg;

  localparam int FACE_W   = 4;  // one hex digit per die, values 1..9
  localparam int PHASE_W  = 3;  // per-die phase counter, die index <= 7
  localparam int DIGITS   = 8;  // physical digits on the display

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SLOW = 2'd2
  } state_e;

  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic logic [7:0] seg7(input logic [FACE_W-1:0] value);
    logic [7:0] pattern;
    unique case (value)
      4'd1:    pattern = 8'hF9;
      4'd2:    pattern = 8'hA4;
      4'd3:    pattern = 8'hB0;
      4'd4:    pattern = 8'h99;
      4'd5:    pattern = 8'h92;
      4'd6:    pattern = 8'h82;
      4'd7:    pattern = 8'hF8;
      4'd8:    pattern = 8'h80;
      4'd9:    pattern = 8'h90;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic logic [FACE_W-1:0] face_next(input logic [FACE_W-1:0] face,
                                                  input int               n_faces);
    return (face == FACE_W'(n_faces)) ? FACE_W'(1) : face + FACE_W'(1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: turns a bouncy, asynchronous active-low push button into a
// single-cycle press pulse.
//   clk, rst  : system clock, synchronous active-high reset
//   btn_n     : raw button pin, active-low, asynchronous to clk
//   press     : one-cycle pulse on an accepted release->press (1->0) transition
// Latency: press is high DB_CYCLES+3 cycles after the pin is first sampled low
// (2 synchroniser stages, DB_CYCLES+1 differing samples, 1 edge-detect register).
module button_conditioner
  import dice_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = width_for(DB_CYCLES);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;     // debounced, accepted pin level
  logic             level_q;   // accepted level one cycle ago, for edge detect
  logic [CNT_W-1:0] db_cnt;

  // NOTE: every register here is state, so it is written with <= only; mixing in
  // blocking assignments would make the synchroniser collapse into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      level_q <= level;
      press   <= level_q & ~level;

      // The count only survives while the synchronised level keeps disagreeing
      // with the accepted one; any sample that agrees (a bounce) restarts it.
      if (sync_q2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DB_CYCLES)) begin
        level  <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dice_roller_mux.sv
// dice_roller_mux: rolls N_DICE independent dice of FACES sides and multiplexes
// them onto an 8-digit common-anode 7-segment display.
//   clk, rst      : system clock, synchronous active-high reset
//   start_n       : start button, active-low, asynchronous
//   stop_n        : stop button, active-low, asynchronous
//   an            : digit anodes, active-low (digits >= N_DICE stay off)
//   seg           : segments {p,g,f,e,d,c,b,a}, active-low, decimal point off
//   faces         : die i value at [4i+3:4i], 1..FACES
//   sum           : registered sum of all faces
//   rolling       : high in ROLL and SLOW
//   result_valid  : one-cycle pulse when a roll completes
module dice_roller_mux
  import dice_pkg::*;
#(
  parameter int N_DICE     = 2,
  parameter int FACES      = 6,
  parameter int SPIN_DIV   = 500000,
  parameter int SCAN_DIV   = 50000,
  parameter int DB_CYCLES  = 500000,
  parameter int SLOW_STEPS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_n,
  input  logic                             stop_n,
  output logic [7:0]                       an,
  output logic [7:0]                       seg,
  output logic [FACE_W*N_DICE-1:0]         faces,
  output logic [$clog2(N_DICE*FACES+1)-1:0] sum,
  output logic                             rolling,
  output logic                             result_valid
);

  localparam int SUM_W  = $clog2(N_DICE*FACES+1);
  localparam int SPIN_W = width_for(SPIN_DIV - 1);
  localparam int SLOW_W = width_for((SPIN_DIV << (SLOW_STEPS - 1)) - 1);
  localparam int K_W    = width_for(SLOW_STEPS - 1);
  localparam int SCAN_W = width_for(SCAN_DIV - 1);
  localparam int DIG_W  = width_for(N_DICE - 1);

  logic               start_press;
  logic               stop_press;
  state_e             state;
  logic [SPIN_W-1:0]  spin_cnt;
  logic               spin_tick;
  logic [SLOW_W-1:0]  slow_cnt;
  logic [SLOW_W-1:0]  slow_limit;
  logic [K_W-1:0]     slow_k;
  logic               slow_last;  // final SLOW advance done, leave on next cycle
  logic [PHASE_W-1:0] phase [N_DICE];
  logic [FACE_W-1:0]  face  [N_DICE];
  logic [SUM_W-1:0]   face_total;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [DIG_W-1:0]   digit;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (start_n),
    .press (start_press)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_stop_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_n (stop_n),
    .press (stop_press)
  );

  assign spin_tick = (spin_cnt == SPIN_W'(SPIN_DIV - 1));

  // Interval before the k-th decelerating advance doubles with each step.
  assign slow_limit = (SLOW_W'(SPIN_DIV) << slow_k) - SLOW_W'(1);

  // Roll controller. Die i advances on every (i+1)-th spin tick, which gives the
  // staggered look while rolling; in SLOW all dice step together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      spin_cnt     <= '0;
      slow_cnt     <= '0;
      slow_k       <= '0;
      slow_last    <= 1'b0;
      rolling      <= 1'b0;
      result_valid <= 1'b0;
      // NOTE: face/phase are small per-die flop arrays, not a RAM, so giving them
      // a reset value is cheap and required for a defined face=1 start state.
      for (int i = 0; i < N_DICE; i++) begin
        face[i]  <= FACE_W'(1);
        phase[i] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Start wins over a simultaneous stop simply because stop is not looked at.
          if (start_press) begin
            state    <= ROLL;
            rolling  <= 1'b1;
            spin_cnt <= '0;
            for (int i = 0; i < N_DICE; i++) phase[i] <= '0;
          end
        end
        ROLL: begin
          if (stop_press) begin
            state     <= SLOW;
            slow_cnt  <= '0;
            slow_k    <= '0;
            slow_last <= 1'b0;
          end else if (spin_tick) begin
            spin_cnt <= '0;
            for (int i = 0; i < N_DICE; i++) begin
              if (phase[i] == PHASE_W'(i)) begin
                face[i]  <= face_next(face[i], FACES);
                phase[i] <= '0;
              end else begin
                phase[i] <= phase[i] + PHASE_W'(1);
              end
            end
          end else begin
            spin_cnt <= spin_cnt + SPIN_W'(1);
          end
        end
        SLOW: begin
          if (slow_last) begin
            // One cycle after the last advance so sum already reflects the result.
            state        <= IDLE;
            rolling      <= 1'b0;
            result_valid <= 1'b1;
            slow_last    <= 1'b0;
          end else if (slow_cnt == slow_limit) begin
            slow_cnt <= '0;
            for (int i = 0; i < N_DICE; i++) face[i] <= face_next(face[i], FACES);
            if (slow_k == K_W'(SLOW_STEPS - 1)) slow_last <= 1'b1;
            else                                 slow_k    <= slow_k + K_W'(1);
          end else begin
            slow_cnt <= slow_cnt + SLOW_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: combinational outputs get a full default before the loop so that no
  // path leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    face_total = '0;
    faces      = '0;
    for (int i = 0; i < N_DICE; i++) begin
      face_total                  = face_total + SUM_W'(face[i]);
      faces[FACE_W*i +: FACE_W]   = face[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sum <= SUM_W'(N_DICE);
    else     sum <= face_total;
  end

  // Display scan keeps running in every state so live values show while rolling.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
      an       <= 8'hFF;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= (digit == DIG_W'(N_DICE - 1)) ? '0 : digit + DIG_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      an  <= ~(8'h01 << digit);
      seg <= seg7(face[digit]);
    end
  end

endmodule

// File: tb/tb_dice_roller_mux.sv
// tb_dice_roller_mux: directed scenarios plus randomized button/reset traffic,
// every output compared each cycle against a behavioural model built from
// absolute cycle times and sample histories.
module tb_dice_roller_mux;

  localparam int ND    = 2;
  localparam int FC    = 6;
  localparam int SPD   = 4;
  localparam int SCD   = 2;
  localparam int DBC   = 3;
  localparam int SLS   = 3;
  localparam int SUM_W = $clog2(ND*FC+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_n = 1'b1;
  logic             stop_n  = 1'b1;
  logic [7:0]       an;
  logic [7:0]       seg;
  logic [4*ND-1:0]  faces;
  logic [SUM_W-1:0] sum;
  logic             rolling;
  logic             result_valid;

  always #5 clk = ~clk;

  dice_roller_mux #(
    .N_DICE     (ND),
    .FACES      (FC),
    .SPIN_DIV   (SPD),
    .SCAN_DIV   (SCD),
    .DB_CYCLES  (DBC),
    .SLOW_STEPS (SLS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_n      (start_n),
    .stop_n       (stop_n),
    .an           (an),
    .seg          (seg),
    .faces        (faces),
    .sum          (sum),
    .rolling      (rolling),
    .result_valid (result_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_face [ND];
  int              m_mode;        // 0 idle, 1 roll, 2 slow
  int              cyc;           // clock edges since reset released
  int              roll_start;
  int              slow_due;
  int              slow_k;
  bit              slow_done;
  bit              model_ok = 1'b0;
  logic [7:0]      exp_an;
  logic [7:0]      exp_seg;
  logic [4*ND-1:0] exp_faces;
  int              exp_sum;
  bit              exp_rv;
  bit              exp_rolling;
  logic [7:0]      hist_st, hist_sp;  // bit k = pin sampled k edges ago
  bit              lvl_st, lvl_sp;
  bit              fell_st, fell_sp;
  bit              prs_st, prs_sp;

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      1:       return 8'hF9;
      2:       return 8'hA4;
      3:       return 8'hB0;
      4:       return 8'h99;
      5:       return 8'h92;
      6:       return 8'h82;
      7:       return 8'hF8;
      8:       return 8'h80;
      9:       return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int adv(input int f);
    return (f % FC) + 1;
  endfunction

  // The accepted level flips once the pin, seen through two synchroniser stages,
  // has disagreed with it for DBC+1 straight samples; a press follows one edge later.
  task automatic btn_model(input logic pin, inout logic [7:0] hist, inout bit lvl,
                           inout bit fell, inout bit prs);
    bit all_diff;
    prs  = fell;
    hist = {hist[6:0], pin};
    all_diff = 1'b1;
    for (int j = 2; j <= DBC + 2; j++) if (hist[j] == lvl) all_diff = 1'b0;
    fell = all_diff && lvl;
    if (all_diff) lvl = ~lvl;
  endtask

  task automatic model_step();
    int d;
    int tick;
    if (rst) begin
      for (int i = 0; i < ND; i++) m_face[i] = 1;
      m_mode = 0; cyc = 0; slow_done = 1'b0; slow_k = 0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_sum = ND; exp_rv = 1'b0;
      hist_st = 8'hFF; hist_sp = 8'hFF; lvl_st = 1'b1; lvl_sp = 1'b1;
      fell_st = 1'b0; fell_sp = 1'b0; prs_st = 1'b0; prs_sp = 1'b0;
      model_ok = 1'b1;
    end else begin
      d       = (cyc / SCD) % ND;
      exp_an  = ~(8'h01 << d);
      exp_seg = seg_of(m_face[d]);
      exp_sum = 0;
      for (int i = 0; i < ND; i++) exp_sum += m_face[i];
      exp_rv  = 1'b0;
      case (m_mode)
        0: if (prs_st) begin
             m_mode = 1;
             roll_start = cyc;
           end
        1: if (prs_sp) begin
             m_mode = 2;
             slow_due = cyc + SPD;
             slow_k = 0;
           end else if ((cyc - roll_start) % SPD == 0) begin
             tick = (cyc - roll_start) / SPD;
             for (int i = 0; i < ND; i++) if (tick % (i + 1) == 0) m_face[i] = adv(m_face[i]);
           end
        default: if (slow_done) begin
             m_mode = 0;
             exp_rv = 1'b1;
             slow_done = 1'b0;
           end else if (cyc == slow_due) begin
             for (int i = 0; i < ND; i++) m_face[i] = adv(m_face[i]);
             if (slow_k == SLS - 1) slow_done = 1'b1;
             else begin
               slow_k++;
               slow_due = cyc + (SPD << slow_k);
             end
           end
      endcase
      btn_model(start_n, hist_st, lvl_st, fell_st, prs_st);
      btn_model(stop_n,  hist_sp, lvl_sp, fell_sp, prs_sp);
      cyc++;
    end
    exp_rolling = (m_mode != 0);
    for (int i = 0; i < ND; i++) exp_faces[4*i +: 4] = m_face[i][3:0];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("an",           an,           exp_an);
      check("seg",          seg,          exp_seg);
      check("faces",        faces,        exp_faces);
      check("sum",          sum,          exp_sum);
      check("rolling",      rolling,      exp_rolling);
      check("result_valid", result_valid, exp_rv);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rv_count;
    int rv_at;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an",      an,           8'hFF);
    check("rst_seg",     seg,          8'hFF);
    check("rst_faces",   faces,        8'h11);
    check("rst_sum",     sum,          2);
    check("rst_rolling", rolling,      0);
    check("rst_rv",      result_valid, 0);
    rst = 1'b0;

    // Roll: start held low 10 cycles, rolling from the 8th edge (E7)
    start_n = 1'b0;
    repeat (7) @(negedge clk);
    check("roll_not_yet", rolling, 0);
    @(negedge clk);
    check("roll_started", rolling, 1);
    repeat (2) @(negedge clk);
    start_n = 1'b1;

    // Stop pressed so it lands right after the 6th spin tick
    repeat (15) @(negedge clk);
    stop_n = 1'b0;
    repeat (6) @(negedge clk);
    stop_n = 1'b1;
    @(negedge clk);
    check("faces_6ticks", faces, 8'h41);
    rv_count = 0;
    rv_at    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (result_valid) begin
        rv_count++;
        rv_at = i;
      end
    end
    check("rv_pulses",     rv_count, 1);
    check("rv_cycle",      rv_at,    30);
    check("final_faces",   faces,    8'h14);
    check("final_sum",     sum,      5);
    check("final_rolling", rolling,  0);

    // Bounce: short low pulses never get accepted
    for (int r = 0; r < 3; r++) begin
      start_n = 1'b0;
      repeat (2) @(negedge clk);
      start_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_rolling", rolling, 0);
    check("bounce_faces",   faces,   8'h14);

    // Scan in IDLE with faces (4,1)
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("an_upper_off", an[7:2], 6'h3F);
      if (an[1:0] == 2'b10) begin
        check("seg_digit0", seg, 8'h99);
      end else begin
        check("an_digit1",  an,  8'hFD);
        check("seg_digit1", seg, 8'hF9);
      end
    end

    // Start and stop together in IDLE -> ROLL
    start_n = 1'b0;
    stop_n  = 1'b0;
    repeat (6) @(negedge clk);
    start_n = 1'b1;
    stop_n  = 1'b1;
    repeat (4) @(negedge clk);
    check("both_roll", rolling, 1);

    // Reset during SLOW aborts without result_valid
    stop_n = 1'b0;
    repeat (6) @(negedge clk);
    stop_n = 1'b1;
    rv_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (result_valid) rv_count++;
    end
    check("slow_rolling", rolling, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_faces",   faces,   8'h11);
    check("abort_rolling", rolling, 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) rv_count++;
    end
    check("abort_no_rv", rv_count, 0);

    // Randomized button traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) start_n = ~start_n;
      if ($urandom_range(0, 15) == 0) stop_n  = ~stop_n;
      rst = ($urandom_range(0, 599) == 0);
    end
    rst     = 1'b0;
    start_n = 1'b1;
    stop_n  = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
